// File: rtl/chunk_serial_adder.sv
// Multi-cycle add/subtract: WIDTH-bit operands are processed CHUNK bits per clock
// through one CHUNK-bit ripple stage, with a registered carry between chunks.
module chunk_serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("chunk_serial_adder: WIDTH must be a multiple of CHUNK, 1 <= CHUNK <= WIDTH");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q, sum_q;
    logic [IW-1:0]    idx_q;
    logic             carry_q, cout_q, ovf_q, busy_q, done_q;

    logic [CHUNK-1:0] chunk_a, chunk_b, chunk_s;
    logic             chunk_c;
    logic [WIDTH-1:0] acc_d;

    // One ripple stage; acc_d already holds the current chunk so the final
    // edge can publish the complete result.
    always_comb begin
        chunk_a = a_q[idx_q*CHUNK +: CHUNK];
        chunk_b = b_q[idx_q*CHUNK +: CHUNK];
        {chunk_c, chunk_s} = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry_q};
        acc_d = acc_q;
        acc_d[idx_q*CHUNK +: CHUNK] = chunk_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= mode ? ~b : b;
                        carry_q <= mode ? 1'b1 : carry_in;
                        idx_q   <= '0;
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                RUN: begin
                    acc_q   <= acc_d;
                    carry_q <= chunk_c;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        sum_q   <= acc_d;
                        cout_q  <= chunk_c;
                        ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                   (acc_d[WIDTH-1] != a_q[WIDTH-1]);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_chunk_serial_adder.sv
// Scoreboard bench for chunk_serial_adder: a 16/8 instance with directed vectors
// and a 32/4 instance with a directed vector plus a randomized reference-model sweep.
module tb_chunk_serial_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        v;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;
    int total = 0;
    int bad   = 0;

    // 16/8 instance
    logic        rst, start, mode, cin;
    logic [15:0] a, b;
    logic        busy, done, cout, ovf;
    logic [15:0] sum;

    // 32/4 instance
    logic        rst2, start2, mode2, cin2;
    logic [31:0] a2, b2;
    logic        busy2, done2, cout2, ovf2;
    logic [31:0] sum2;

    chunk_serial_adder #(.WIDTH(16), .CHUNK(8)) dut16 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
        .carry_in(cin), .busy(busy), .done(done), .sum(sum),
        .carry_out(cout), .overflow(ovf)
    );

    chunk_serial_adder #(.WIDTH(32), .CHUNK(4)) dut32 (
        .clk(clk), .rst(rst2), .start(start2), .mode(mode2), .a(a2), .b(b2),
        .carry_in(cin2), .busy(busy2), .done(done2), .sum(sum2),
        .carry_out(cout2), .overflow(ovf2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Independent reference: unsigned compare for carry, signed range for overflow.
    function automatic exp_t model32(input logic m, input logic [31:0] x, input logic [31:0] y,
                                     input logic c);
        exp_t   r;
        longint sx, sy, sr;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (m) begin
            r.s = x - y;
            r.c = (x >= y);
            sr  = sx - sy;
        end else begin
            r.s = x + y + 32'(c);
            r.c = ({32'd0, x} + {32'd0, y} + 64'(c)) > 64'hFFFF_FFFF;
            sr  = sx + sy + longint'(c);
        end
        r.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return r;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (q1.size() == 0) chk("spurious_done16", 32'd1, 32'd0);
            else begin
                e1 = q1.pop_front();
                chk("sum16", {16'd0, sum}, {16'd0, e1.s[15:0]});
                chk("cout16", {31'd0, cout}, {31'd0, e1.c});
                chk("ovf16", {31'd0, ovf}, {31'd0, e1.v});
            end
        end
    end

    always @(negedge clk) begin
        if (done2) begin
            if (q2.size() == 0) chk("spurious_done32", 32'd1, 32'd0);
            else begin
                e2 = q2.pop_front();
                chk("sum32", sum2, e2.s);
                chk("cout32", {31'd0, cout2}, {31'd0, e2.c});
                chk("ovf32", {31'd0, ovf2}, {31'd0, e2.v});
            end
        end
    end

    task automatic op16(input logic m, input logic [15:0] x, input logic [15:0] y, input logic c,
                        input logic [15:0] es, input logic ec, input logic ev);
        int n;
        q1.push_back('{{16'd0, es}, ec, ev});
        @(posedge clk);
        @(negedge clk);
        mode = m; a = x; b = y; cin = c; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; mode = ~m; cin = ~c; a = 16'($urandom); b = 16'($urandom);
        n = 0;
        while (!done && n < 40) begin
            chk("busy16", {31'd0, busy}, 32'd1);
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency16", n, 2);
        chk("busy_in_done16", {31'd0, busy}, 32'd0);
    endtask

    task automatic op32(input logic m, input logic [31:0] x, input logic [31:0] y, input logic c);
        int n;
        q2.push_back(model32(m, x, y, c));
        @(posedge clk);
        @(negedge clk);
        mode2 = m; a2 = x; b2 = y; cin2 = c; start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0; mode2 = ~m; cin2 = ~c; a2 = $urandom; b2 = $urandom;
        n = 0;
        while (!done2 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency32", n, 8);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; mode = 1'b0; cin = 1'b0; a = '0; b = '0;
        rst2 = 1'b1; start2 = 1'b0; mode2 = 1'b0; cin2 = 1'b0; a2 = '0; b2 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; rst2 = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);

        op16(1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
        op16(1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        op16(1'b0, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);
        op16(1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        op16(1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        op16(1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        op16(1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0);

        // Start during RUN is dropped; start held in DONE is taken back-to-back.
        q1.push_back('{32'h0000_2345, 1'b0, 1'b0});
        q1.push_back('{32'h0000_0FFF, 1'b1, 1'b0});
        @(posedge clk);
        @(negedge clk);
        mode = 1'b0; a = 16'h1234; b = 16'h1111; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("no_early_done", {31'd0, done}, 32'd0);
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("b2b_first_lat", n, 1);
        mode = 1'b1; a = 16'h1000; b = 16'h0001; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 1;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("b2b_gap", n, 3);

        // Reset in the first RUN cycle aborts without a done pulse.
        @(posedge clk);
        @(negedge clk);
        mode = 1'b0; a = 16'hAAAA; b = 16'h5555; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_sum", {16'd0, sum}, 32'd0);
        chk("abort_cout", {31'd0, cout}, 32'd0);
        repeat (6) @(posedge clk);
        op16(1'b0, 16'h0100, 16'h0200, 1'b1, 16'h0301, 1'b0, 1'b0);

        op32(1'b0, 32'h0FFF_FFFF, 32'h0000_0001, 1'b0);
        chk("dir32_sum", sum2, 32'h1000_0000);
        for (int i = 0; i < 1000; i++) begin
            op32(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
        end

        repeat (4) @(posedge clk);
        #1;
        chk("q16_drained", q1.size(), 0);
        chk("q32_drained", q2.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
